asym_fifo_read_wider: RTL
=========================

Name: asym_fifo_read_wider

Overview:
Single-clock narrow-to-wide FIFO. It accepts WIDTHA-bit words on a valid/ready slave port and packs RATIO consecutive words into one WIDTHB-bit word. Packed words are presented on a valid/ready master port. It sits on the gather side of datapaths whose wide-write/narrow-read asymmetric RAMs scatter data. Storage is an asymmetric RAM with a narrow write port and a wide read port.

Parameters:
WIDTHA, 4, write (narrow) word width
WIDTHB, 16, read (wide) word width; must equal RATIO*WIDTHA, RATIO a power of 2, at least 2
DEPTHB, 256, capacity in wide words; power of 2
ADDRWIDTHB, 8, log2(DEPTHB)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
s_valid  in  1  narrow word offered
s_ready  out  1  narrow word can be accepted
s_data  in  WIDTHA  narrow word
m_valid  out  1  wide word presented
m_ready  in  1  downstream accepts wide word
m_data  out  WIDTHB  wide word
level_b  out  ADDRWIDTHB+1  complete wide words held (RAM plus output pipeline)
lanes_pending  out  log2(RATIO)  narrow words in the current incomplete wide word

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values (rst_n low at an edge):
  - All pointers and counters 0.
  - s_ready 0 while rst_n is low; 1 on the first edge after release.
  - m_valid 0, m_data 0, level_b 0, lanes_pending 0.
  - RAM contents are not cleared; stale data must never be presented.
- Write accept: s_valid && s_ready at an edge.
  - s_data is written to RAM narrow address wptr; wptr increments.
  - wptr is ADDRWIDTHB+log2(RATIO) bits and wraps naturally.
- Lane order: the first accepted word of a group goes to m_data[WIDTHA-1:0]; lane i goes to bits [(i+1)*WIDTHA-1 -: WIDTHA].
- A wide word is complete after lane RATIO-1 is accepted. Partial words are never visible; lanes_pending equals wptr modulo RATIO.
- Read pipeline: a 2-stage chain.
  - Stage 1 is the RAM registered read output, with valid bit rd_v.
  - Stage 2 is the output register (m_data/m_valid).
  - A read of wide address rptr is issued in a cycle when complete unissued words exist and (rd_v + m_valid - (m_valid&&m_ready)) < 2.
  - On issue, rptr increments.
  - Stage 1 holds when no read is issued (RAM enable low).
  - Stage 1 moves to stage 2 when stage 2 is empty or being popped.
- Latency, empty pipeline:
  - Last-lane accept at edge t.
  - Read issued in the cycle after t.
  - Stage 1 valid at t+2.
  - m_valid high after edge t+3.
- Throughput: one wide word per cycle when words are available and m_ready is held high.
- m_data/m_valid are stable while m_valid && !m_ready.
- Occupancy:
  - level_b = completed wide words minus popped wide words (pop = m_valid && m_ready).
  - The narrow free count is based on pops, not issues, so issued but unpopped RAM slots are never overwritten.
- Full:
  - s_ready is registered: s_ready = (narrow words held < DEPTHB*RATIO), evaluated from next-state counts.
  - A pop in cycle t raises s_ready at edge t+1.
  - A simultaneous accept and pop leaves the count unchanged.
- Empty: m_valid is 0 whenever both stages are invalid; no underflow is possible.
- Pointer wrap: wrap is transparent; order is preserved across any number of wraps.
- Reset mid-operation: all in-flight and stored words are discarded. No word accepted before reset appears after it.

Decomposition:
- Shared package asym_fifo_pkg:
  - log2 function and max/min constants.
  - Derived localparams RATIO, log2RATIO, narrow address width.
  - Elaboration-time parameter legality checks.
- Sub-module asym_ram_sdp_read_wider:
  - Single clock.
  - Narrow write port (we, addr, di).
  - Wide read port (en, addr, registered do).
  - No reset.
  - Wide word at address a = narrow locations {a,0} .. {a,RATIO-1}, lane 0 in the LSBs.
- The top level holds pointers, counters and the output stage.

Test Plan:
1. Release reset, write 0x1,0x2,0x3,0x4 back-to-back, m_ready=1 -> m_valid rises 3 cycles after the 0x4 accept; m_data=0x4321; level_b 1 then 0 after pop.
2. Write 0xA,0xB,0xC only -> m_valid stays 0; level_b=0; lanes_pending=3. Write 0xD -> m_data=0xDCBA.
3. m_ready=0, s_valid=1 with an incrementing pattern -> exactly 1024 accepts; s_ready low after edge of accept 1024; level_b=256; m_data=0x3210.
4. From full, m_ready=1 for one cycle -> that edge pops 0x3210; s_ready high on the next edge; level_b=255; next write fills lane 0 of slot 0.
5. Random s_valid/m_ready (50%), 2000 wide words -> output equals packed input in order across 7+ pointer wraps; no gaps at 100% m_ready once data is available.
6. With m_valid=1 and level_b=5, pull rst_n low for 1 cycle -> next edge m_valid=0, level_b=0, lanes_pending=0; first output after 4 new writes is new data only.

Source files
------------

// File: rtl/asym_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asym_fifo_pkg
// Description : Shared helpers for the narrow-to-wide FIFO: log2, ratio and
//               address-width derivation, parameter legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package asym_fifo_pkg;

    localparam int c_MIN_RATIO   = 2;
    localparam int c_MAX_ADDRW   = 24;

    // Ceiling log2, for elaboration-time constants.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit isPow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int ratioOf(input int widthA, input int widthB);
        return widthB / widthA;
    endfunction

    function automatic int narrowAddrWidth(input int widthA, input int widthB, input int addrWidthB);
        return addrWidthB + log2(ratioOf(widthA, widthB));
    endfunction

    function automatic bit paramsLegal(input int widthA, input int widthB,
                                       input int depthB, input int addrWidthB);
        int ratio;
        ratio = ratioOf(widthA, widthB);
        return (widthA > 0) &&
               (ratio * widthA == widthB) &&
               (ratio >= c_MIN_RATIO) && isPow2(ratio) &&
               isPow2(depthB) && ((1 << addrWidthB) == depthB) &&
               (addrWidthB <= c_MAX_ADDRW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/asym_fifo_read_wider_if.sv
`default_nettype none
// ============================================================================
// Module      : asym_fifo_read_wider_if
// Description : Narrow write stream plus wide read stream of the FIFO.
//               slave = FIFO side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface asym_fifo_read_wider_if #(
    parameter int WIDTHA = 4,
    parameter int WIDTHB = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [WIDTHA-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [WIDTHB-1:0] m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface
`default_nettype wire

// File: rtl/asym_ram_sdp_read_wider.sv
`default_nettype none
// ============================================================================
// Module      : asym_ram_sdp_read_wider
// Description : Simple dual-port RAM, narrow write port, wide registered read
//               port. Wide word a = narrow {a,0}..{a,RATIO-1}, lane 0 in LSBs.
// Revision    : 1.0 - initial release
// ============================================================================
module asym_ram_sdp_read_wider
    import asym_fifo_pkg::*;
#(
    parameter int WIDTHA     = 4,
    parameter int WIDTHB     = 16,
    parameter int DEPTHB     = 256,
    parameter int ADDRWIDTHB = 8
)(
    input  wire                                                 clk,
    input  wire                                                 we,
    input  wire  [narrowAddrWidth(WIDTHA, WIDTHB, ADDRWIDTHB)-1:0] wrAddr,
    input  wire  [WIDTHA-1:0]                                   wrData,
    input  wire                                                 rdEn,
    input  wire  [ADDRWIDTHB-1:0]                               rdAddr,
    output logic [WIDTHB-1:0]                                   rdData
);
    localparam int c_LANE_W = log2(ratioOf(WIDTHA, WIDTHB));
    localparam int c_NAW    = ADDRWIDTHB + c_LANE_W;

    logic [WIDTHB-1:0]     r_mem [DEPTHB];
    logic [ADDRWIDTHB-1:0] w_wordAddr;
    int                    w_laneBase;

    assign w_wordAddr = wrAddr[c_NAW-1:c_LANE_W];
    assign w_laneBase = int'(wrAddr[c_LANE_W-1:0]) * WIDTHA;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[w_wordAddr][w_laneBase +: WIDTHA] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rdEn) begin
            rdData <= r_mem[rdAddr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/asym_fifo_read_wider.sv
`default_nettype none
// ============================================================================
// Module      : asym_fifo_read_wider
// Description : Single-clock FIFO packing RATIO narrow words into one wide
//               word, with a 2-stage (RAM register + output register) read.
// Revision    : 1.0 - initial release
// ============================================================================
module asym_fifo_read_wider
    import asym_fifo_pkg::*;
#(
    parameter int WIDTHA     = 4,
    parameter int WIDTHB     = 16,
    parameter int DEPTHB     = 256,
    parameter int ADDRWIDTHB = 8
)(
    input  wire                                        clk,
    input  wire                                        rst_n,
    asym_fifo_read_wider_if.slave                      bus,
    output logic [ADDRWIDTHB:0]                        level_b,
    output logic [log2(ratioOf(WIDTHA, WIDTHB))-1:0]   lanes_pending
);
    localparam int c_RATIO  = ratioOf(WIDTHA, WIDTHB);
    localparam int c_LANE_W = log2(c_RATIO);
    localparam int c_NAW    = ADDRWIDTHB + c_LANE_W;
    localparam int c_CAP_N  = DEPTHB * c_RATIO;

    if (!paramsLegal(WIDTHA, WIDTHB, DEPTHB, ADDRWIDTHB)) begin : g_paramCheck
        $error("asym_fifo_read_wider: illegal WIDTHA/WIDTHB/DEPTHB/ADDRWIDTHB");
    end

    logic [c_NAW-1:0]      r_wptr;
    logic [ADDRWIDTHB-1:0] r_rptr;
    logic [c_NAW:0]        r_held;
    logic [ADDRWIDTHB:0]   r_unissued;
    logic [ADDRWIDTHB:0]   r_levelB;
    logic                  r_cmplDly;
    logic                  r_sReady;
    logic                  r_rdValid;
    logic                  r_mValid;
    logic [WIDTHB-1:0]     r_mData;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_pop;
    logic                  w_advance;
    logic                  w_issue;
    logic [c_NAW:0]        w_heldNext;
    logic [WIDTHB-1:0]     w_ramDout;

    assign w_accept   = bus.s_valid && r_sReady;
    assign w_complete = w_accept && (r_wptr[c_LANE_W-1:0] == {c_LANE_W{1'b1}});
    assign w_pop      = r_mValid && bus.m_ready;
    assign w_advance  = r_rdValid && (!r_mValid || bus.m_ready);
    // Issue unless both stages stay occupied through this cycle.
    assign w_issue    = (r_unissued != '0) && !(r_rdValid && r_mValid && !bus.m_ready);

    // Free space counts popped words only, so issued-but-unpopped slots stay protected.
    assign w_heldNext = r_held + (c_NAW + 1)'(w_accept)
                      - (w_pop ? (c_NAW + 1)'(c_RATIO) : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_held     <= '0;
            r_unissued <= '0;
            r_levelB   <= '0;
            r_cmplDly  <= 1'b0;
            r_sReady   <= 1'b0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + 1'b1;
            if (w_issue)  r_rptr <= r_rptr + 1'b1;
            r_held     <= w_heldNext;
            r_cmplDly  <= w_complete;
            r_unissued <= r_unissued + (ADDRWIDTHB + 1)'(r_cmplDly) - (ADDRWIDTHB + 1)'(w_issue);
            r_levelB   <= r_levelB + (ADDRWIDTHB + 1)'(w_complete) - (ADDRWIDTHB + 1)'(w_pop);
            r_sReady   <= (w_heldNext < (c_NAW + 1)'(c_CAP_N));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdValid <= 1'b0;
        end else if (w_issue) begin
            r_rdValid <= 1'b1;
        end else if (w_advance) begin
            r_rdValid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mValid <= 1'b0;
            r_mData  <= '0;
        end else if (w_advance) begin
            r_mValid <= 1'b1;
            r_mData  <= w_ramDout;
        end else if (w_pop) begin
            r_mValid <= 1'b0;
        end
    end

    asym_ram_sdp_read_wider #(
        .WIDTHA     (WIDTHA),
        .WIDTHB     (WIDTHB),
        .DEPTHB     (DEPTHB),
        .ADDRWIDTHB (ADDRWIDTHB)
    ) u_ram (
        .clk    (clk),
        .we     (w_accept),
        .wrAddr (r_wptr),
        .wrData (bus.s_data),
        .rdEn   (w_issue),
        .rdAddr (r_rptr),
        .rdData (w_ramDout)
    );

    assign bus.s_ready   = r_sReady;
    assign bus.m_valid   = r_mValid;
    assign bus.m_data    = r_mData;
    assign level_b       = r_levelB;
    assign lanes_pending = r_wptr[c_LANE_W-1:0];
endmodule
`default_nettype wire
